uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter peripheral on the processor's data bus, alongside the existing switch/LED/7-segment I/O unit. It occupies the word-aligned window 0x1010–0x101F, adjacent to the existing I/O range. Software stores bytes to a TX data register, and they enter a small FIFO. A serializer drains the FIFO onto a single `tx` line as 8N1 frames at a programmable bit period. The top level qualifies `we` with the address-window decode and muxes `rd` into ReadData when the address falls in the window.

---
 rtl/uart_tx_mmio.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a small TX FIFO drained by a programmable-rate serializer.
// Registers are decoded on a[3:2]: TXDATA, STATUS, DIVISOR, reserved.
module uart_tx_mmio #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV_RESET = 433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   divisor_q, divisor_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          sel_data, sel_status, sel_div;
    logic          push_ok, pop, empty, full, busy, period_done;
    logic          unused_bits;

    assign unused_bits = ^{a[31:4], a[1:0], wd[31:16]};

    assign sel_data    = we && (a[3:2] == 2'd0);
    assign sel_status  = we && (a[3:2] == 2'd1);
    assign sel_div     = we && (a[3:2] == 2'd2);
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign push_ok     = sel_data && !full;
    assign busy        = (state_q != StIdle);
    assign period_done = (cyc_q == period_q);
    assign tx          = tx_q;

    // Full is judged before the edge, so a push into a full FIFO drops even alongside a pop.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (sel_status && wd[3]) begin
            overflow_d = 1'b0;
        end
        if (sel_data && full) begin
            overflow_d = 1'b1;
        end
        divisor_d = sel_div ? wd[15:0] : divisor_q;
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        period_d = period_q;
        pop      = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rptr_q];
                    period_d = divisor_q;
                    cyc_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (period_done) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            StData: begin
                if (period_done) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            StStop: begin
                if (period_done) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // tx is registered from the next state so the line changes on the transition edge.
        tx_d = (state_d == StStart) ? 1'b0 : (state_d == StData) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= 16'(DIV_RESET);
            period_q   <= '0;
            cyc_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            divisor_q  <= divisor_d;
            period_q   <= period_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            if (push_ok) begin
                mem_q[wptr_q] <= wd[7:0];
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    always_comb begin
        rd = '0;
        case (a[3:2])
            2'd1:    rd = {24'h0, 4'(count_q), overflow_q, busy, full, empty};
            2'd2:    rd = {16'h0, divisor_q};
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, frame timing, FIFO overflow and reset.
// tx is logged every cycle so frames can be compared against a bit-level model after the fact.
module tb_uart_tx_mmio;
    localparam int LOGN = 2048;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx;

    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   last_idx = 0;
    logic txlog [LOGN];

    uart_tx_mmio #(
        .DEPTH(4),
        .DIV_RESET(433)
    ) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .a(a),
        .wd(wd),
        .rd(rd),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry i holds tx as left by the i-th rising edge since time 0.
    always @(negedge clk) begin
        if (ncyc < LOGN) begin
            txlog[ncyc] = tx;
            ncyc = ncyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] frame_exp(input logic [7:0] b, input int p);
        logic [127:0] v;
        int k;
        v = '0;
        for (int i = 0; i < 10 * p; i++) begin
            k = i / p;
            v[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
        v[10*p] = 1'b1;
        return v;
    endfunction

    task automatic get_log(input int s, input int n, output logic [127:0] v, output bit ok);
        v  = '0;
        ok = (s + n <= ncyc);
        for (int i = 0; i < n; i++) begin
            if (s + i < LOGN) v[i] = txlog[s+i];
        end
    endtask

    task automatic wrreg(input logic [3:0] off, input logic [31:0] d);
        we = 1'b1;
        a  = {28'h0, off};
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        last_idx = ncyc;
    endtask

    task automatic rdreg(input logic [3:0] off, output logic [31:0] v);
        a = {28'h0, off};
        #1;
        v = rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_status: got %h want 00000001", v);
        end
        rdreg(4'h8, v);
        checks++;
        if (v !== 32'h0000_01B1) begin
            errors++;
            $display("FAIL reset_divisor: got %h want 000001b1", v);
        end
        rdreg(4'h0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h want 00000000", v);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0]  v;
        logic [127:0] obs;
        bit           ok;
        int           w;
        wrreg(4'h8, 32'd3);
        wrreg(4'h0, 32'h0000_00A5);
        w = last_idx;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL a5_tx_after_write: got %b want 1", tx);
        end
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0010) begin
            errors++;
            $display("FAIL a5_status_queued: got %h want 00000010", v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL a5_start_latency: got %b want 0", tx);
        end
        repeat (39) @(posedge clk);
        #1;
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0005) begin
            errors++;
            $display("FAIL a5_busy_last_stop: got %h want 00000005", v);
        end
        @(posedge clk);
        #1;
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL a5_busy_cleared: got %h want 00000001", v);
        end
        repeat (3) @(posedge clk);
        #1;
        get_log(w + 1, 41, obs, ok);
        checks++;
        if (!ok || obs !== frame_exp(8'hA5, 4)) begin
            errors++;
            $display("FAIL a5_frame: got %h want %h", obs, frame_exp(8'hA5, 4));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  v;
        logic [127:0] obs;
        bit           ok;
        int           w;
        wrreg(4'h8, 32'd0);
        wrreg(4'h0, 32'h01);
        w = last_idx;
        for (int i = 2; i <= 5; i++) wrreg(4'h0, 32'(i));
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0046) begin
            errors++;
            $display("FAIL b2b_status_full: got %h want 00000046", v);
        end
        repeat (60) @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            get_log(w + 1 + 11 * n, 11, obs, ok);
            checks++;
            if (!ok || obs !== frame_exp(8'(n + 1), 1)) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h want %h", n, obs, frame_exp(8'(n + 1), 1));
            end
        end
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL b2b_status_done: got %h want 00000001", v);
        end
    endtask

    task automatic test_overflow();
        logic [31:0]  v;
        logic [127:0] obs;
        logic [7:0]   exp_b [5];
        bit           ok;
        int           w;
        exp_b = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        wrreg(4'h8, 32'd7);
        wrreg(4'h0, 32'h11);
        w = last_idx;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) wrreg(4'h0, 32'h21 + 32'(i));
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_004E) begin
            errors++;
            $display("FAIL ovf_status_set: got %h want 0000004e", v);
        end
        wrreg(4'h4, 32'h0000_0007);
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_004E) begin
            errors++;
            $display("FAIL ovf_status_other_bits: got %h want 0000004e", v);
        end
        wrreg(4'h4, 32'h0000_0008);
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0046) begin
            errors++;
            $display("FAIL ovf_w1c: got %h want 00000046", v);
        end
        repeat (410) @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            get_log(w + 1 + 81 * n, 81, obs, ok);
            checks++;
            if (!ok || obs !== frame_exp(exp_b[n], 8)) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %h want %h", n, obs, frame_exp(exp_b[n], 8));
            end
        end
    endtask

    task automatic test_divisor_change();
        logic [31:0]  v;
        logic [127:0] obs;
        bit           ok;
        int           w;
        wrreg(4'h8, 32'hABCD_0003);
        wrreg(4'hC, 32'hFFFF_FFFF);
        rdreg(4'h8, v);
        checks++;
        if (v !== 32'h0000_0003) begin
            errors++;
            $display("FAIL div_upper_bits: got %h want 00000003", v);
        end
        rdreg(4'hC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read: got %h want 00000000", v);
        end
        wrreg(4'h0, 32'hFFFF_FF3C);
        w = last_idx;
        wrreg(4'h0, 32'h0F);
        repeat (8) @(posedge clk);
        #1;
        wrreg(4'h8, 32'd1);
        repeat (60) @(posedge clk);
        #1;
        get_log(w + 1, 41, obs, ok);
        checks++;
        if (!ok || obs !== frame_exp(8'h3C, 4)) begin
            errors++;
            $display("FAIL divchg_frame_old: got %h want %h", obs, frame_exp(8'h3C, 4));
        end
        get_log(w + 42, 21, obs, ok);
        checks++;
        if (!ok || obs !== frame_exp(8'h0F, 2)) begin
            errors++;
            $display("FAIL divchg_frame_new: got %h want %h", obs, frame_exp(8'h0F, 2));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0]  v;
        logic [127:0] obs;
        logic [127:0] expv;
        logic [127:0] mask;
        bit           ok;
        int           w;
        wrreg(4'h8, 32'd3);
        wrreg(4'h0, 32'h81);
        w = last_idx;
        wrreg(4'h0, 32'h82);
        wrreg(4'h0, 32'h83);
        repeat (19) @(posedge clk);
        #1;
        // Reset lands on the second clock of data bit 4, together with a TXDATA write.
        reset = 1'b1;
        we    = 1'b1;
        a     = 32'h0;
        wd    = 32'h77;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tx: got %b want 1", tx);
        end
        rdreg(4'h4, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL rstmid_status: got %h want 00000001", v);
        end
        rdreg(4'h8, v);
        checks++;
        if (v !== 32'h0000_01B1) begin
            errors++;
            $display("FAIL rstmid_divisor: got %h want 000001b1", v);
        end
        repeat (32) @(posedge clk);
        #1;
        mask = (128'd1 << 21) - 128'd1;
        expv = frame_exp(8'h81, 4) & mask;
        get_log(w + 1, 21, obs, ok);
        checks++;
        if (!ok || obs !== expv) begin
            errors++;
            $display("FAIL rstmid_partial: got %h want %h", obs, expv);
        end
        get_log(w + 22, 30, obs, ok);
        checks++;
        if (!ok || obs !== ((128'd1 << 30) - 128'd1)) begin
            errors++;
            $display("FAIL rstmid_idle_after: got %h want %h", obs, (128'd1 << 30) - 128'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_divisor_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
